// File: rtl/slave_internal_response_rd_arbiter.sv
// Round-robin merge of internal AXI read-response sources into one R stream.
// A source keeps the grant for a whole burst; a one-entry output register absorbs backpressure.
module slave_internal_response_rd_arbiter #(
   parameter int NUM_SRC    = 2,
   parameter int ID_WIDTH   = 8,
   parameter int RESP_WIDTH = 2,
   parameter int SRC_W      = $clog2(NUM_SRC)
) (
   input  logic                             ACLK,
   input  logic                             ARESET,
   input  logic [NUM_SRC-1:0]               in_rvalid,
   input  logic [NUM_SRC*RESP_WIDTH-1:0]    in_rresp,
   input  logic [NUM_SRC*ID_WIDTH-1:0]      in_rid,
   input  logic [NUM_SRC-1:0]               in_rlast,
   output logic [NUM_SRC-1:0]               in_rready,
   output logic                             out_rvalid,
   output logic [RESP_WIDTH-1:0]            out_rresp,
   output logic [ID_WIDTH-1:0]              out_rid,
   output logic                             out_rlast,
   output logic [SRC_W-1:0]                 out_src,
   input  logic                             out_rready,
   output logic                             dbg_locked,
   output logic [SRC_W-1:0]                 dbg_rr_ptr
);

   // Handshake: a beat moves on any edge where valid and ready are both high;
   // valid may not drop or change payload until that happens, and ready never
   // looks at the same source's valid in a way that forms a loop.
   typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

   state_t                 state_q, state_d;
   logic [SRC_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [SRC_W-1:0]       lock_idx_q, lock_idx_d;
   logic                   out_rvalid_q, out_rvalid_d;
   logic [RESP_WIDTH-1:0]  out_rresp_q, out_rresp_d;
   logic [ID_WIDTH-1:0]    out_rid_q, out_rid_d;
   logic                   out_rlast_q, out_rlast_d;
   logic [SRC_W-1:0]       out_src_q, out_src_d;

   logic [SRC_W-1:0]       grant;
   logic [SRC_W-1:0]       cand;
   logic                   grant_vld;
   logic                   load;
   logic                   accept;

   assign load = !out_rvalid_q || out_rready;

   // Reverse scan so the candidate nearest rr_ptr_q is the one left standing.
   always_comb begin
      grant     = lock_idx_q;
      grant_vld = 1'b0;
      cand      = '0;
      if (state_q == ST_LOCKED) begin
         grant     = lock_idx_q;
         grant_vld = 1'b1;
      end else begin
         for (int k = NUM_SRC - 1; k >= 0; k--) begin
            cand = SRC_W'((int'(rr_ptr_q) + k) % NUM_SRC);
            if (in_rvalid[cand]) begin
               grant     = cand;
               grant_vld = 1'b1;
            end
         end
      end
   end

   always_comb begin
      in_rready = '0;
      if (!ARESET && grant_vld) begin
         in_rready[grant] = load;
      end
   end

   assign accept = !ARESET && grant_vld && load && in_rvalid[grant];

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      lock_idx_d   = lock_idx_q;
      out_rvalid_d = out_rvalid_q;
      out_rresp_d  = out_rresp_q;
      out_rid_d    = out_rid_q;
      out_rlast_d  = out_rlast_q;
      out_src_d    = out_src_q;
      if (accept) begin
         out_rvalid_d = 1'b1;
         out_rresp_d  = in_rresp[int'(grant)*RESP_WIDTH +: RESP_WIDTH];
         out_rid_d    = in_rid[int'(grant)*ID_WIDTH +: ID_WIDTH];
         out_rlast_d  = in_rlast[grant];
         out_src_d    = grant;
         if (in_rlast[grant]) begin
            state_d  = ST_IDLE;
            rr_ptr_d = (grant == SRC_W'(NUM_SRC - 1)) ? '0 : grant + SRC_W'(1);
         end else begin
            state_d    = ST_LOCKED;
            lock_idx_d = grant;
         end
      end else if (out_rready) begin
         out_rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= '0;
         lock_idx_q   <= '0;
         out_rvalid_q <= 1'b0;
         out_rresp_q  <= '0;
         out_rid_q    <= '0;
         out_rlast_q  <= 1'b0;
         out_src_q    <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         lock_idx_q   <= lock_idx_d;
         out_rvalid_q <= out_rvalid_d;
         out_rresp_q  <= out_rresp_d;
         out_rid_q    <= out_rid_d;
         out_rlast_q  <= out_rlast_d;
         out_src_q    <= out_src_d;
      end
   end

   assign out_rvalid = out_rvalid_q;
   assign out_rresp  = out_rresp_q;
   assign out_rid    = out_rid_q;
   assign out_rlast  = out_rlast_q;
   assign out_src    = out_src_q;
   assign dbg_locked = (state_q == ST_LOCKED);
   assign dbg_rr_ptr = rr_ptr_q;

endmodule
